vga_phase_timing: RTL and testbench

//  Two-phase VGA 640x480@60 timing generator feeding the donut renderer.
//  clk runs at 2x pixel rate (50.35 MHz); each pixel lasts two clocks, phase 0 then phase 1.
//  The renderer uses those two clocks to time-share its squarer bank.

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 71 +++++++
 rtl/vga_phase_timing.sv | 100 ++++++++++
 tb/tb_vga_phase_timing.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and region type for the 640x480@60 VGA timing generator.
package vga_timing_pkg;

  // Horizontal timing in pixels
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  // Vertical timing in lines
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // 1 = active-low sync pulses, as VGA 640x480 expects
  localparam bit SYNC_NEG  = 1'b1;
  localparam int FC_STEP   = 8;

  // Width of the hpos/vpos counters
  localparam int POS_W     = 10;

  // Position of an axis counter inside its line or frame
  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } region_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter plus the
// ACTIVE -> FRONT -> SYNC -> BACK region FSM that tracks it.
// 'region' is the region the axis occupies after the current edge, so the parent
// can register its decoded outputs in step with 'count'. 'wrap' is combinational
// so the next axis can advance on the same edge.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY_LEN = 640,
  parameter int FRONT_LEN   = 16,
  parameter int SYNC_LEN    = 96,
  parameter int BACK_LEN    = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [POS_W-1:0] count,
  output region_t          region,
  output logic             wrap
);

  localparam int               TOTAL    = DISPLAY_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;
  localparam logic [POS_W-1:0] LAST     = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] FRONT_AT = POS_W'(DISPLAY_LEN);
  localparam logic [POS_W-1:0] SYNC_AT  = POS_W'(DISPLAY_LEN + FRONT_LEN);
  localparam logic [POS_W-1:0] BACK_AT  = POS_W'(DISPLAY_LEN + FRONT_LEN + SYNC_LEN);
  localparam logic [POS_W-1:0] ONE      = POS_W'(1);

  region_t          state;
  region_t          state_next;
  logic [POS_W-1:0] count_next;

  assign wrap   = advance && (count == LAST);
  assign region = state_next;

  // Next position: step on advance, wrapping after the last position
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    count_next = count;
    if (advance) begin
      count_next = wrap ? '0 : count + ONE;
    end
  end

  // Region FSM: move on when the new position reaches the next boundary
  always_comb begin
    state_next = state;
    if (advance) begin
      case (state)
        ACTIVE:  if (count_next == FRONT_AT) state_next = FRONT;
        FRONT:   if (count_next == SYNC_AT)  state_next = SYNC;
        SYNC:    if (count_next == BACK_AT)  state_next = BACK;
        BACK:    if (wrap)                   state_next = ACTIVE;
        default: state_next = ACTIVE;
      endcase
    end
  end

  // Position and region state registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
      state <= ACTIVE;
    end else begin
      count <= count_next;
      state <= state_next;
    end
  end

endmodule

// File: rtl/vga_phase_timing.sv
// Two-phase VGA timing generator: clk runs at twice the pixel rate, each pixel
// spans phase 0 then phase 1, and hpos advances on the phase 1 -> 0 edge.
// All outputs are registered from next-state decode so they line up with hpos/vpos.
// Optional feature: define FRAME_COUNT_EN to enable the frame_count register;
// otherwise frame_count is tied to zero.
module vga_phase_timing #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK,
  parameter bit SYNC_NEG  = vga_timing_pkg::SYNC_NEG,
  parameter int FC_STEP   = vga_timing_pkg::FC_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       phase,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  import vga_timing_pkg::*;

  region_t h_region;
  region_t v_region;
  logic    h_wrap;
  logic    v_wrap;

  // Horizontal axis steps once per pixel, on the phase 1 -> 0 edge
  vga_axis_counter #(
    .DISPLAY_LEN (H_DISPLAY),
    .FRONT_LEN   (H_FRONT),
    .SYNC_LEN    (H_SYNC),
    .BACK_LEN    (H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (phase),
    .count   (hpos),
    .region  (h_region),
    .wrap    (h_wrap)
  );

  // Vertical axis steps when the horizontal axis wraps
  vga_axis_counter #(
    .DISPLAY_LEN (V_DISPLAY),
    .FRONT_LEN   (V_FRONT),
    .SYNC_LEN    (V_SYNC),
    .BACK_LEN    (V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap),
    .count   (vpos),
    .region  (v_region),
    .wrap    (v_wrap)
  );

  // Phase toggle and registered decode of the next-state regions and wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase       <= 1'b0;
      display_on  <= 1'b1;
      hsync       <= SYNC_NEG;
      vsync       <= SYNC_NEG;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      phase       <= ~phase;
      display_on  <= (h_region == ACTIVE) && (v_region == ACTIVE);
      hsync       <= (h_region == SYNC) ^ SYNC_NEG;
      vsync       <= (v_region == SYNC) ^ SYNC_NEG;
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef FRAME_COUNT_EN
  // Frame counter steps on the same edge that raises frame_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= 8'd0;
    end else if (v_wrap) begin
      frame_count <= frame_count + 8'(FC_STEP);
    end
  end
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_phase_timing.sv
// Scoreboard bench for vga_phase_timing: a small-geometry instance (8/1/2/1 x 4/1/1/1)
// covers whole frames, a default 640x480 instance covers several full lines.
// Expected outputs come from an arithmetic model driven by the number of clock
// edges since reset release; random reset pulses restart the model.
module tb_vga_phase_timing;

  typedef struct packed {
    logic       phase;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
  } obs_t;

  typedef struct packed {
    int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb;
  } cfg_t;

  localparam cfg_t CFG_S = '{hd: 8, hf: 1, hs: 2, hb: 1, vd: 4, vf: 1, vs: 1, vb: 1};
  localparam cfg_t CFG_B = '{hd: 640, hf: 16, hs: 96, hb: 48, vd: 480, vf: 10, vs: 2, vb: 33};
  localparam int   FRAME_S = 2 * 12 * 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_phase, s_de, s_hs, s_vs, s_ls, s_fs;
  logic [9:0] s_hpos, s_vpos;
  logic [7:0] s_fc;
  logic       b_phase, b_de, b_hs, b_vs, b_ls, b_fs;
  logic [9:0] b_hpos, b_vpos;
  logic [7:0] b_fc;

  vga_phase_timing #(
    .H_DISPLAY (8), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
  ) dut_s (
    .clk (clk), .rst_n (rst_n), .phase (s_phase), .hpos (s_hpos), .vpos (s_vpos),
    .display_on (s_de), .hsync (s_hs), .vsync (s_vs), .line_start (s_ls),
    .frame_start (s_fs), .frame_count (s_fc)
  );

  vga_phase_timing dut_b (
    .clk (clk), .rst_n (rst_n), .phase (b_phase), .hpos (b_hpos), .vpos (b_vpos),
    .display_on (b_de), .hsync (b_hs), .vsync (b_vs), .line_start (b_ls),
    .frame_start (b_fs), .frame_count (b_fc)
  );

  obs_t got_s, got_b;
  assign got_s = '{s_phase, s_hpos, s_vpos, s_de, s_hs, s_vs, s_ls, s_fs, s_fc};
  assign got_b = '{b_phase, b_hpos, b_vpos, b_de, b_hs, b_vs, b_ls, b_fs, b_fc};

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  obs_t exp_q_s[$];
  obs_t exp_q_b[$];

  // Reference: t clock edges after reset release, pixel = t/2, everything else by arithmetic
  function automatic obs_t model(input cfg_t c, input int tick);
    obs_t o;
    int ht, vt, pix, h, v, frames;
    ht     = c.hd + c.hf + c.hs + c.hb;
    vt     = c.vd + c.vf + c.vs + c.vb;
    pix    = tick / 2;
    h      = pix % ht;
    v      = (pix / ht) % vt;
    frames = tick / (2 * ht * vt);
    o.phase       = (tick % 2) == 1;
    o.hpos        = 10'(h);
    o.vpos        = 10'(v);
    o.display_on  = (h < c.hd) && (v < c.vd);
    o.hsync       = !((h >= c.hd + c.hf) && (h < c.hd + c.hf + c.hs));
    o.vsync       = !((v >= c.vd + c.vf) && (v < c.vd + c.vf + c.vs));
    o.line_start  = (tick > 0) && (tick % (2 * ht) == 0);
    o.frame_start = (tick > 0) && (tick % (2 * ht * vt) == 0);
`ifdef FRAME_COUNT_EN
    o.frame_count = 8'((8 * frames) % 256);
`else
    o.frame_count = 8'd0;
`endif
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("ph=%0d h=%0d v=%0d de=%0d hs=%0d vs=%0d ls=%0d fs=%0d fc=%0d",
                     o.phase, o.hpos, o.vpos, o.display_on, o.hsync, o.vsync,
                     o.line_start, o.frame_start, o.frame_count);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s t=%0d: got {%s} expected {%s}", name, t, fmt(act), fmt(want));
    end
  endtask

  task automatic check_val(input string name, input int act, input int want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s t=%0d: got %0d expected %0d", name, t, act, want);
    end
  endtask

  // Stimulus side of the scoreboard: each edge pushes what the outputs must become
  always @(posedge clk) begin
    if (!rst_n) t = 0;
    else        t = t + 1;
    exp_q_s.push_back(model(CFG_S, t));
    exp_q_b.push_back(model(CFG_B, t));
  end

  // Monitor: compare on the falling edge, away from the update edge
  always @(negedge clk) begin
    if (exp_q_s.size() > 0) check("small_cycle", got_s, exp_q_s.pop_front());
    if (exp_q_b.size() > 0) check("vga_cycle", got_b, exp_q_b.pop_front());
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Assert reset between edges and confirm both instances clear without a clock
  task automatic reset_pulse(input int hold);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_small", got_s, model(CFG_S, 0));
    check("async_reset_vga", got_b, model(CFG_B, 0));
    repeat (hold) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held from time zero; monitor checks reset values during it
    run_cycles(3);
    #1 rst_n = 1'b1;
    run_cycles(40);

    // Mid-frame reset: small instance in horizontal sync of line 2
    reset_pulse(2);
    run_cycles(67);
    check_val("mid_frame_hpos", int'(s_hpos), 9);
    check_val("mid_frame_vpos", int'(s_vpos), 2);
    reset_pulse(1);

    // Random run lengths and reset hold times
    for (int i = 0; i < 6; i++) begin
      run_cycles(int'($urandom_range(20, 500)));
      reset_pulse(int'($urandom_range(1, 3)));
    end

    // Long uninterrupted run: 33 small frames, 3+ full VGA lines
    run_cycles(32 * FRAME_S + 1);
`ifdef FRAME_COUNT_EN
    check_val("frame_count_32", int'(s_fc), 0);
`else
    check_val("frame_count_32", int'(s_fc), 0);
`endif
    run_cycles(FRAME_S);
`ifdef FRAME_COUNT_EN
    check_val("frame_count_33", int'(s_fc), 8);
`else
    check_val("frame_count_33", int'(s_fc), 0);
`endif
    run_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
